riscv_lsu_m: RTL

- Memory-stage load/store unit of the 5-stage RV32I pipeline.
- Holds the EX/MEM pipeline register and consumes the execute stage's ALU result (address) and forwarded store data.
- Drives a valid/ready data-memory bus, builds byte enables, sign/zero-extends load data and stalls upstream stages while a bus transaction is outstanding.
- Supplies o_alu_result_m to the forwarding path and o_read_data_m to writeback.

---
 rtl/riscv_lsu_m_pkg.sv | 67 ++++++
 rtl/riscv_load_ext.sv | 29 ++
 rtl/riscv_lsu_m.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/riscv_lsu_m_pkg.sv
// Shared definitions for the memory-stage load/store unit: data width,
// funct3 access codes, LSU state encodings and lane/byte-enable helpers.
// Optional build macro used by riscv_lsu_m: RISCV_LSU_TIMEOUT_EN.
package riscv_lsu_m_pkg;

    localparam int XLEN = 32;

    // Load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } lsu_state_e;

    // Access size lives in funct3[1:0]: 00 byte, 01 half, anything else word.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        logic result;
        case (funct3[1:0])
            2'b00:   result = 1'b0;
            2'b01:   result = addr_lo[0];
            default: result = (addr_lo != 2'b00);
        endcase
        return result;
    endfunction

    // Loads always fetch the whole word; stores enable only the touched lanes.
    function automatic logic [3:0] build_be(input logic [2:0] funct3,
                                            input logic [1:0] addr_lo,
                                            input logic       is_store);
        logic [3:0] be;
        if (!is_store) begin
            be = 4'b1111;
        end else begin
            case (funct3[1:0])
                2'b00:   be = 4'b0001 << addr_lo;
                2'b01:   be = 4'b0011 << addr_lo;
                default: be = 4'b1111;
            endcase
        end
        return be;
    endfunction

    // Replicate the store operand so every enabled lane sees the right bytes.
    function automatic logic [XLEN-1:0] build_wdata(input logic [2:0]      funct3,
                                                    input logic [XLEN-1:0] data);
        logic [XLEN-1:0] wd;
        case (funct3[1:0])
            2'b00:   wd = {4{data[7:0]}};
            2'b01:   wd = {2{data[15:0]}};
            default: wd = data;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/riscv_load_ext.sv
// Load lane select and sign/zero extension. Purely combinational so it can be
// shared by any path that returns a raw memory word.
module riscv_load_ext
    import riscv_lsu_m_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed lane and extend it according to funct3.
    always_comb begin
        byte_s = rdata[8*addr_lo +: 8];
        half_s = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:   data = {{(XLEN-8){byte_s[7]}}, byte_s};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_s};
            F3_LH:   data = {{(XLEN-16){half_s[15]}}, half_s};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, half_s};
            F3_LW:   data = rdata;
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/riscv_lsu_m.sv
// Memory-stage load/store unit: EX/MEM register, valid/ready data bus master,
// byte-enable generation and load extension. Stalls upstream while a bus
// transaction is outstanding.
// Build macro RISCV_LSU_TIMEOUT_EN adds a bus-wait watchdog (TIMEOUT_CYCLES).
module riscv_lsu_m
    import riscv_lsu_m_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic [XLEN-1:0] i_alu_result_e,
    input  logic [XLEN-1:0] i_write_data_e,
    input  logic            i_mem_read_e,
    input  logic            i_mem_write_e,
    input  logic [2:0]      i_funct3_e,
    output logic [XLEN-1:0] o_alu_result_m,
    output logic [XLEN-1:0] o_read_data_m,
    output logic            o_stall_m,
    output logic            o_misaligned_m,
    output logic            o_bus_err_m,
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [XLEN-1:0] o_dmem_wdata,
    output logic [3:0]      o_dmem_be,
    input  logic            i_dmem_ready,
    input  logic            i_dmem_rvalid,
    input  logic [XLEN-1:0] i_dmem_rdata
);

    lsu_state_e      state_r;
    logic [XLEN-1:0] alu_r;
    logic [2:0]      funct3_r;
    logic            is_store_r;
    logic [XLEN-1:0] read_data_r;
    logic            misaligned_r;
    logic            req_r;
    logic            we_r;
    logic [XLEN-1:0] addr_r;
    logic [XLEN-1:0] wdata_r;
    logic [3:0]      be_r;

    logic            mem_op_s;
    logic            misaligned_s;
    logic [XLEN-1:0] ext_data_s;

`ifdef RISCV_LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_r;
    logic             bus_err_r;
`endif

    assign mem_op_s     = i_mem_read_e | i_mem_write_e;
    assign misaligned_s = is_misaligned(i_funct3_e, i_alu_result_e[1:0]);

    riscv_load_ext u_load_ext (
        .rdata   (i_dmem_rdata),
        .addr_lo (alu_r[1:0]),
        .funct3  (funct3_r),
        .data    (ext_data_s)
    );

    // EX/MEM capture, bus request sequencing and load writeback.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_r      <= ST_IDLE;
            alu_r        <= {XLEN{1'b0}};
            funct3_r     <= 3'b000;
            is_store_r   <= 1'b0;
            read_data_r  <= {XLEN{1'b0}};
            misaligned_r <= 1'b0;
            req_r        <= 1'b0;
            we_r         <= 1'b0;
            addr_r       <= {XLEN{1'b0}};
            wdata_r      <= {XLEN{1'b0}};
            be_r         <= 4'b0000;
`ifdef RISCV_LSU_TIMEOUT_EN
            cnt_r        <= {CNT_W{1'b0}};
            bus_err_r    <= 1'b0;
`endif
        end else begin
            misaligned_r <= 1'b0;
`ifdef RISCV_LSU_TIMEOUT_EN
            bus_err_r    <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    // Not stalled: the EX/MEM register follows execute every edge.
                    alu_r      <= i_alu_result_e;
                    funct3_r   <= i_funct3_e;
                    is_store_r <= i_mem_write_e;
                    if (mem_op_s && misaligned_s) begin
                        misaligned_r <= 1'b1;
                    end else if (mem_op_s) begin
                        state_r <= ST_REQ;
                        req_r   <= 1'b1;
                        we_r    <= i_mem_write_e;
                        addr_r  <= {i_alu_result_e[XLEN-1:2], 2'b00};
                        be_r    <= build_be(i_funct3_e, i_alu_result_e[1:0], i_mem_write_e);
                        wdata_r <= build_wdata(i_funct3_e, i_write_data_e);
`ifdef RISCV_LSU_TIMEOUT_EN
                        cnt_r   <= {CNT_W{1'b0}};
`endif
                    end
                end
                ST_REQ: begin
                    if (i_dmem_ready) begin
                        req_r   <= 1'b0;
                        state_r <= is_store_r ? ST_IDLE : ST_WAIT;
`ifdef RISCV_LSU_TIMEOUT_EN
                        cnt_r   <= {CNT_W{1'b0}};
                    end else if (cnt_r == CNT_LAST) begin
                        req_r     <= 1'b0;
                        bus_err_r <= 1'b1;
                        state_r   <= ST_IDLE;
                        if (!is_store_r) begin
                            read_data_r <= {XLEN{1'b0}};
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
`endif
                    end
                end
                ST_WAIT: begin
                    if (i_dmem_rvalid) begin
                        read_data_r <= ext_data_s;
                        state_r     <= ST_IDLE;
`ifdef RISCV_LSU_TIMEOUT_EN
                    end else if (cnt_r == CNT_LAST) begin
                        bus_err_r   <= 1'b1;
                        read_data_r <= {XLEN{1'b0}};
                        state_r     <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
`endif
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    req_r   <= 1'b0;
                end
            endcase
        end
    end

    assign o_stall_m      = (state_r != ST_IDLE);
    assign o_alu_result_m = alu_r;
    assign o_read_data_m  = read_data_r;
    assign o_misaligned_m = misaligned_r;
    assign o_dmem_req     = req_r;
    assign o_dmem_we      = we_r;
    assign o_dmem_addr    = addr_r;
    assign o_dmem_wdata   = wdata_r;
    assign o_dmem_be      = be_r;
`ifdef RISCV_LSU_TIMEOUT_EN
    assign o_bus_err_m    = bus_err_r;
`else
    assign o_bus_err_m    = 1'b0;
`endif

endmodule
